// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and constants for the SRAM slave.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'd0,
        HSIZE_HALF = 3'd1,
        HSIZE_WORD = 3'd2
    } hsize_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StData,
        StErr1,
        StErr2
    } slv_state_t;

    // Little-endian byte lanes for an aligned transfer of the given size.
    function automatic logic [3:0] lane_en(input logic [2:0] size, input logic [1:0] offs);
        case (size)
            3'd0:    lane_en = 4'b0001 << offs;
            3'd1:    lane_en = offs[1] ? 4'b1100 : 4'b0011;
            default: lane_en = 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb_slv_mem.sv
// Word array with one byte-enabled write port and an asynchronous read port.
module ahb_slv_mem #(
    parameter int unsigned MEM_DEPTH  = 256,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned IDX_W      = 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [IDX_W-1:0]      idx_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];

    // Contents are deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM slave. Define AHB_SLV_WAIT_EN to insert WAIT_STATES wait cycles
// into every valid transfer; otherwise valid transfers are zero-wait.
module ahb_sram_slave #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [ADDR_WIDTH-1:0] HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [DATA_WIDTH-1:0] HWDATA,
    input  logic                  HREADY,
    output logic [DATA_WIDTH-1:0] HRDATA,
    output logic                  HREADYOUT,
    output logic                  HRESP
);
    import ahb_pkg::*;

    localparam int unsigned IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH + 1)'(4 * MEM_DEPTH);

    if (WAIT_STATES < 1 || WAIT_STATES > 15) begin : g_bad_wait
        $error("WAIT_STATES must be within 1..15");
    end

    slv_state_t state_q, state_d, accept_state;
    logic [IDX_W+1:0]      addr_q;
    logic [2:0]            size_q;
    logic                  write_q, err_q;
    logic                  accept, addr_err, mem_we;
    logic [3:0]            mem_be;
    logic [DATA_WIDTH-1:0] mem_rdata;

`ifdef AHB_SLV_WAIT_EN
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);
    logic [3:0] cnt_q, cnt_d;
`endif

    assign addr_err = ({1'b0, HADDR} >= ADDR_LIMIT) || (HSIZE > 3'd2) ||
                      ((HSIZE == HSIZE_HALF) && HADDR[0]) ||
                      ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00));

    // New address phases are only taken in states whose HREADYOUT is high.
    assign accept = HSEL && HREADY &&
                    ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ)) &&
                    (state_q inside {StIdle, StData, StErr2});

    always_comb begin
        state_d = state_q;
`ifdef AHB_SLV_WAIT_EN
        cnt_d        = cnt_q;
        accept_state = addr_err ? StErr1 : StWait;
`else
        accept_state = addr_err ? StErr1 : StData;
`endif
        case (state_q)
            StIdle, StData, StErr2: begin
                if (accept) begin
                    state_d = accept_state;
`ifdef AHB_SLV_WAIT_EN
                    cnt_d = addr_err ? 4'd0 : WAIT_LOAD;
`endif
                end else begin
                    state_d = StIdle;
                end
            end
            StWait: begin
`ifdef AHB_SLV_WAIT_EN
                if (cnt_q <= 4'd1) begin
                    state_d = StData;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
`else
                state_d = StData;
`endif
            end
            StErr1:  state_d = StErr2;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= StIdle;
`ifdef AHB_SLV_WAIT_EN
            cnt_q   <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
`ifdef AHB_SLV_WAIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            addr_q  <= '0;
            size_q  <= 3'd0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (accept) begin
            addr_q  <= HADDR[IDX_W+1:0];
            size_q  <= HSIZE;
            write_q <= HWRITE;
            err_q   <= addr_err;
        end
    end

    assign mem_be    = lane_en(size_q, addr_q[1:0]);
    assign mem_we    = (state_q == StData) && write_q && !err_q;
    assign HREADYOUT = !((state_q == StWait) || (state_q == StErr1));
    assign HRESP     = ((state_q == StErr1) || (state_q == StErr2)) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = ((state_q == StData) && !write_q && !err_q) ? mem_rdata : '0;

    ahb_slv_mem #(
        .MEM_DEPTH (MEM_DEPTH),
        .DATA_WIDTH(DATA_WIDTH),
        .IDX_W     (IDX_W)
    ) u_mem (
        .clk_i  (HCLK),
        .we_i   (mem_we),
        .be_i   (mem_be),
        .idx_i  (addr_q[IDX_W+1:2]),
        .wdata_i(HWDATA),
        .rdata_o(mem_rdata)
    );

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave against a byte-array reference model.
module tb_ahb_sram_slave;

    localparam int unsigned MEM_DEPTH   = 256;
    localparam int unsigned WAIT_STATES = 2;
`ifdef AHB_SLV_WAIT_EN
    localparam int EXP_WAIT = WAIT_STATES;
`else
    localparam int EXP_WAIT = 0;
`endif
    localparam int BOUND = 40;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = 2'd0;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'd0;
    logic [31:0] HWDATA = '0;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic        hready_low = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] ref_mem [0:4*MEM_DEPTH-1];

    assign HREADY = HREADYOUT & ~hready_low;

    always #5 HCLK = ~HCLK;

    ahb_sram_slave #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .MEM_DEPTH  (MEM_DEPTH),
        .WAIT_STATES(WAIT_STATES)
    ) dut (
        .HCLK     (HCLK),
        .HRESETn  (HRESETn),
        .HSEL     (HSEL),
        .HADDR    (HADDR),
        .HTRANS   (HTRANS),
        .HWRITE   (HWRITE),
        .HSIZE    (HSIZE),
        .HWDATA   (HWDATA),
        .HREADY   (HREADY),
        .HRDATA   (HRDATA),
        .HREADYOUT(HREADYOUT),
        .HRESP    (HRESP)
    );

    function automatic logic model_err(input logic [31:0] a, input logic [2:0] s);
        return (a >= 32'(4 * MEM_DEPTH)) || (s > 3'd2) || (s == 3'd1 && a[0]) ||
               (s == 3'd2 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        int base = int'(a) & ~3;
        return {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
    endfunction

    // A transfer of 2**size bytes; each byte travels on the lane its address selects.
    task automatic ref_write(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        int n = 1 << s;
        for (int i = 0; i < n; i++) begin
            int ba = int'(a) + i;
            ref_mem[ba] = d[8*(ba % 4) +: 8];
        end
    endtask

    // Single transfer driver; entered and left 1 time unit after a rising edge.
    task automatic xfer(input logic wr, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic seq, output logic [31:0] rdata,
                        output int waits, output logic resp0, output logic resp1);
        HSEL = 1'b1; HTRANS = {1'b1, seq}; HADDR = addr; HWRITE = wr; HSIZE = size;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'd0; HWDATA = wdata;
        waits = 0;
        @(negedge HCLK);
        resp0 = HRESP;
        while (HREADYOUT !== 1'b1 && waits < BOUND) begin
            waits++;
            @(negedge HCLK);
        end
        resp1 = HRESP;
        rdata = HRDATA;
        if (waits >= BOUND) begin
            n_cmp++; n_bad++;
            $display("FAIL xfer_timeout addr=%h: HREADYOUT stuck low for %0d cycles", addr, waits);
        end
        @(posedge HCLK); #1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (HREADYOUT !== 1'b1) begin n_bad++; $display("FAIL reset_hreadyout got=%b exp=1", HREADYOUT); end
        n_cmp++; if (HRESP !== 1'b0) begin n_bad++; $display("FAIL reset_hresp got=%b exp=0", HRESP); end
        n_cmp++; if (HRDATA !== 32'h0) begin n_bad++; $display("FAIL reset_hrdata got=%h exp=0", HRDATA); end
        @(negedge HCLK); @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
    endtask

    task automatic test_word_rw();
        logic [31:0] rd; int w; logic r0, r1;
        xfer(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 1'b0, rd, w, r0, r1);
        ref_write(32'h10, 3'd2, 32'hDEADBEEF);
        n_cmp++; if (w !== EXP_WAIT) begin n_bad++; $display("FAIL word_wr_waits got=%0d exp=%0d", w, EXP_WAIT); end
        n_cmp++; if (rd !== 32'h0 || r1 !== 1'b0) begin n_bad++; $display("FAIL word_wr_resp got=%h/%b exp=0/0", rd, r1); end
        xfer(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, rd, w, r0, r1);
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL word_rd_data got=%h exp=deadbeef", rd); end
        n_cmp++; if (w !== EXP_WAIT) begin n_bad++; $display("FAIL word_rd_waits got=%0d exp=%0d", w, EXP_WAIT); end
        n_cmp++; if (r0 !== 1'b0 || r1 !== 1'b0) begin n_bad++; $display("FAIL word_rd_resp got=%b%b exp=00", r0, r1); end
    endtask

    task automatic test_byte_write();
        logic [31:0] rd; int w; logic r0, r1;
        xfer(1'b1, 3'd2, 32'h10, 32'h11223344, 1'b0, rd, w, r0, r1);
        ref_write(32'h10, 3'd2, 32'h11223344);
        xfer(1'b1, 3'd0, 32'h13, 32'hAA000000, 1'b0, rd, w, r0, r1);
        ref_write(32'h13, 3'd0, 32'hAA000000);
        xfer(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, rd, w, r0, r1);
        n_cmp++; if (rd !== 32'hAA223344) begin n_bad++; $display("FAIL byte_write got=%h exp=aa223344", rd); end
        xfer(1'b1, 3'd1, 32'h12, 32'h5A5A0000, 1'b1, rd, w, r0, r1);
        ref_write(32'h12, 3'd1, 32'h5A5A0000);
        xfer(1'b0, 3'd0, 32'h11, 32'h0, 1'b0, rd, w, r0, r1);
        n_cmp++; if (rd !== ref_word(32'h10)) begin n_bad++; $display("FAIL half_write got=%h exp=%h", rd, ref_word(32'h10)); end
    endtask

    task automatic test_back_to_back();
        int w;
        HSEL = 1'b1; HTRANS = 2'd2; HADDR = 32'h20; HWRITE = 1'b1; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        HWDATA = 32'h5; HWRITE = 1'b0;
        w = 0;
        @(negedge HCLK);
        while (HREADYOUT !== 1'b1 && w < BOUND) begin w++; @(negedge HCLK); end
        n_cmp++; if (w !== EXP_WAIT) begin n_bad++; $display("FAIL b2b_wr_waits got=%0d exp=%0d", w, EXP_WAIT); end
        @(posedge HCLK); #1;
        ref_write(32'h20, 3'd2, 32'h5);
        HSEL = 1'b0; HTRANS = 2'd0;
        w = 0;
        @(negedge HCLK);
        while (HREADYOUT !== 1'b1 && w < BOUND) begin w++; @(negedge HCLK); end
        n_cmp++; if (w !== EXP_WAIT) begin n_bad++; $display("FAIL b2b_rd_waits got=%0d exp=%0d", w, EXP_WAIT); end
        n_cmp++; if (HRDATA !== 32'h5 || HRESP !== 1'b0) begin
            n_bad++; $display("FAIL b2b_rd_data got=%h/%b exp=00000005/0", HRDATA, HRESP);
        end
        @(posedge HCLK); #1;
    endtask

    task automatic test_error();
        logic [31:0] rd; int w; logic r0, r1;
        xfer(1'b0, 3'd2, 32'h400, 32'h0, 1'b0, rd, w, r0, r1);
        n_cmp++; if (w !== 1 || r0 !== 1'b1 || r1 !== 1'b1 || rd !== 32'h0) begin
            n_bad++; $display("FAIL err_range got waits=%0d resp=%b%b data=%h exp 1/11/0", w, r0, r1, rd);
        end
        xfer(1'b0, 3'd1, 32'h3, 32'h0, 1'b0, rd, w, r0, r1);
        n_cmp++; if (w !== 1 || r0 !== 1'b1 || r1 !== 1'b1 || rd !== 32'h0) begin
            n_bad++; $display("FAIL err_align got waits=%0d resp=%b%b data=%h exp 1/11/0", w, r0, r1, rd);
        end
        xfer(1'b1, 3'd1, 32'h11, 32'hFFFFFFFF, 1'b0, rd, w, r0, r1);
        xfer(1'b1, 3'd3, 32'h10, 32'hFFFFFFFF, 1'b0, rd, w, r0, r1);
        n_cmp++; if (w !== 1 || r1 !== 1'b1) begin n_bad++; $display("FAIL err_size got waits=%0d resp=%b exp 1/1", w, r1); end
        xfer(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, rd, w, r0, r1);
        n_cmp++; if (rd !== ref_word(32'h10)) begin n_bad++; $display("FAIL err_nowrite got=%h exp=%h", rd, ref_word(32'h10)); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; int w; logic r0, r1;
        xfer(1'b1, 3'd2, 32'h30, 32'hCAFEF00D, 1'b0, rd, w, r0, r1);
        ref_write(32'h30, 3'd2, 32'hCAFEF00D);
        HSEL = 1'b1; HTRANS = 2'd2; HADDR = 32'h30; HWRITE = 1'b1; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'd0; HWDATA = 32'h12345678;
        @(negedge HCLK); #1;
        HRESETn = 1'b0;
        #1;
        n_cmp++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0) begin
            n_bad++; $display("FAIL rst_mid_outputs got=%b/%b/%h exp=1/0/0", HREADYOUT, HRESP, HRDATA);
        end
        @(negedge HCLK);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;
        xfer(1'b0, 3'd2, 32'h30, 32'h0, 1'b0, rd, w, r0, r1);
        n_cmp++; if (rd !== 32'hCAFEF00D) begin n_bad++; $display("FAIL rst_mid_nowrite got=%h exp=cafef00d", rd); end
    endtask

    task automatic test_idle_busy();
        logic [31:0] rd; int w; logic r0, r1;
        HADDR = 32'h10; HWRITE = 1'b1; HSIZE = 3'd2; HWDATA = 32'hFFFFFFFF;
        for (int k = 0; k < 6; k++) begin
            HSEL = (k < 4); HTRANS = (k < 2) ? 2'd0 : ((k < 4) ? 2'd1 : 2'd2);
            @(negedge HCLK);
            n_cmp++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0) begin
                n_bad++; $display("FAIL idle_busy k=%0d got=%b/%b/%h exp=1/0/0", k, HREADYOUT, HRESP, HRDATA);
            end
            @(posedge HCLK); #1;
        end
        hready_low = 1'b1; HSEL = 1'b1; HTRANS = 2'd2;
        @(posedge HCLK); #1;
        hready_low = 1'b0; HSEL = 1'b0; HTRANS = 2'd0;
        @(negedge HCLK);
        n_cmp++; if (HREADYOUT !== 1'b1) begin n_bad++; $display("FAIL hready_low_ignored got=%b exp=1", HREADYOUT); end
        @(posedge HCLK); #1;
        xfer(1'b0, 3'd2, 32'h10, 32'h0, 1'b0, rd, w, r0, r1);
        n_cmp++; if (rd !== ref_word(32'h10)) begin n_bad++; $display("FAIL idle_nowrite got=%h exp=%h", rd, ref_word(32'h10)); end
    endtask

    task automatic test_random();
        logic [31:0] rd, a, d; logic [2:0] s; logic wr, e; int w; logic r0, r1;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            xfer(1'b1, 3'd2, 32'h100 + 32'(4 * i), d, 1'b0, rd, w, r0, r1);
            ref_write(32'h100 + 32'(4 * i), 3'd2, d);
        end
        for (int i = 0; i < 80; i++) begin
            a = 32'h100 + 32'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) a = a | 32'h400;
            s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            if ($urandom_range(0, 2) != 0 && s <= 3'd2) a = a & ~((32'h1 << s) - 32'h1);
            wr = 1'($urandom_range(0, 1));
            d = $urandom;
            e = model_err(a, s);
            xfer(wr, s, a, d, 1'($urandom_range(0, 1)), rd, w, r0, r1);
            n_cmp++;
            if (e ? (w !== 1 || r0 !== 1'b1 || r1 !== 1'b1)
                  : (w !== EXP_WAIT || r0 !== 1'b0 || r1 !== 1'b0)) begin
                n_bad++;
                $display("FAIL rand_resp i=%0d a=%h s=%0d wr=%b got waits=%0d resp=%b%b exp_err=%b",
                         i, a, s, wr, w, r0, r1, e);
            end
            n_cmp++;
            if (rd !== ((e || wr) ? 32'h0 : ref_word(a))) begin
                n_bad++;
                $display("FAIL rand_data i=%0d a=%h s=%0d wr=%b got=%h exp=%h",
                         i, a, s, wr, rd, (e || wr) ? 32'h0 : ref_word(a));
            end
            if (wr && !e) ref_write(a, s, d);
        end
    endtask

    initial begin
        test_reset();
        test_word_rw();
        test_byte_write();
        test_back_to_back();
        test_error();
        test_reset_mid();
        test_idle_busy();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 Parameters, one per line (name, default, meaning):
  ADDR_WIDTH  32   HADDR width.
  DATA_WIDTH  32   HWDATA/HRDATA width; only 32 is supported.
  MEM_DEPTH   256  Number of 32-bit memory words (byte range 0..4*MEM_DEPTH-1).
  WAIT_STATES 2    Wait cycles per transfer when AHB_SLV_WAIT_EN is defined; range 1..15.
REQ-002 Ports, one per line (name, direction, width, meaning):
  HCLK       in   1   Single clock; all state updates on its rising edge.
  HRESETn    in   1   Reset, asynchronous, active-low.
  HSEL       in   1   Slave select.
  HADDR      in   ADDR_WIDTH  Address.
  HTRANS     in   2   IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
  HWRITE     in   1   1 = write.
  HSIZE      in   3   0=byte, 1=half, 2=word.
  HWDATA     in   DATA_WIDTH  Write data, valid in the data phase.
  HREADY     in   1   Bus ready (the mux-returned HREADYOUT).
  HRDATA     out  DATA_WIDTH  Read data.
  HREADYOUT  out  1   Slave ready.
  HRESP      out  1   0 = OKAY, 1 = ERROR.

Function
REQ-003 An address phase SHALL be accepted only when HSEL=1, HREADY=1 and HTRANS[1]=1; addr, write, size and an error flag SHALL be registered at that edge.
REQ-004 Address-phase inputs SHALL be ignored while HREADY=0.
REQ-005 IDLE/BUSY transfers, and cycles with HSEL=0, SHALL get a zero-wait OKAY response (HREADYOUT=1, HRESP=0) with no memory access.
REQ-006 The error flag SHALL be set for any of:
  - address >= 4*MEM_DEPTH;
  - HSIZE > 2;
  - misalignment (half with HADDR[0]=1; word with HADDR[1:0]!=0).
REQ-007 FSM states are IDLE, WAIT, DATA, ERR1 and ERR2.
REQ-008 FSM transitions from IDLE:
  - to ERR1 if the accepted transfer is flagged as an error;
  - otherwise to WAIT when the wait feature is enabled;
  - otherwise to DATA.
REQ-009 WAIT SHALL hold HREADYOUT=0 for exactly WAIT_STATES cycles, counted by a down-counter, then go to DATA.
REQ-010 DATA SHALL drive HREADYOUT=1 and HRESP=0, which completes the transfer.
REQ-011 From DATA the FSM SHALL return to IDLE, or re-enter WAIT/DATA/ERR1 directly if a new transfer is accepted in that same cycle (pipelined back-to-back).
REQ-012 Error response sequence:
  - ERR1 SHALL drive HREADYOUT=0, HRESP=1;
  - ERR2 SHALL drive HREADYOUT=1, HRESP=1;
  - ERR2 SHALL handle acceptance like DATA;
  - an errored transfer SHALL NOT write memory and SHALL drive HRDATA=0.
REQ-013 A write SHALL update memory on the edge ending DATA, using byte lanes decoded from size and addr[1:0] (little-endian). All other bytes are unchanged.
REQ-014 A read SHALL return the full addressed word on HRDATA while in DATA. HRDATA SHALL be 0 in all other states and for writes.
REQ-015 A read whose data phase immediately follows a write to the same word SHALL return the newly written bytes.
REQ-016 Memory index SHALL be addr[log2(MEM_DEPTH)+1:2]; upper address bits are used only for the range check.

Reset
REQ-017 Asserting HRESETn low SHALL immediately force: state=IDLE, wait counter=0, HREADYOUT=1, HRESP=0, HRDATA=0, registered controls cleared.
REQ-018 A reset in the middle of a transfer SHALL abort it with no memory write. Memory contents are not reset.
REQ-019 Reset release SHALL be synchronous to HCLK; the first transfer is accepted on the first edge after release.

Configuration
REQ-020 The macro AHB_SLV_WAIT_EN SHALL control the wait feature:
  - defined: the WAIT state and counter are compiled in, and every valid transfer takes WAIT_STATES+1 cycles in its data phase;
  - undefined: the WAIT state and counter are absent, and valid transfers complete with zero wait;
  - error responses are two cycles in both builds.

Structure
REQ-021 Shared package ahb_pkg SHALL hold:
  - htrans_t enum (IDLE/BUSY/NONSEQ/SEQ);
  - hsize_t enum (BYTE/HALF/WORD);
  - HRESP_OKAY/HRESP_ERROR constants;
  - the slave FSM state enum.
REQ-022 One sub-module, ahb_slv_mem, SHALL hold the word array: one write port with 4-bit byte enable and an asynchronous read port.

Verification
REQ-023 The bench SHALL cover these directed scenarios (stimulus -> required response):
  - Word write 0xDEADBEEF @0x10, then word read @0x10 -> HRDATA=0xDEADBEEF, HRESP=0; with the macro, 2 wait cycles on each transfer.
  - Byte write 0xAA @0x13 over 0x11223344 -> read @0x10 returns 0xAA223344.
  - Back-to-back NONSEQ write @0x20 = 0x5, then read @0x20 -> read data phase returns 0x00000005.
  - Word read @0x400 with MEM_DEPTH=256 -> HREADYOUT 0 then 1, HRESP 1 in both cycles, HRDATA=0; half access @0x3 -> same ERROR response.
  - HRESETn pulsed low during a write WAIT state -> HREADYOUT=1 immediately; the target word is unchanged after reset.
  - IDLE and BUSY with HSEL=1 -> HREADYOUT=1, HRESP=0, no state change.
